stopwatch_counter: RTL and testbench

//  MM:SS stopwatch time base that drives the four BCD digit inputs (d0..d3) of the

---
 rtl/stopwatch_counter.sv | 159 +++++++++++++++
 tb/tb_stopwatch_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch time base: button synchronisers, IDLE/RUN/PAUSE control, prescaled BCD count.
// Optional lap-freeze view enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       wrap,
  output logic       lap
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef logic [3:0][3:0] bcd4_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] ss_sync, clr_sync;
  logic                   ss_e, clr_e, ss_p, clr_p;
  logic [PW-1:0]          presc, presc_n;
  bcd4_t                  cnt, cnt_n, disp_n;
  logic                   tick, wrap_n;

  // Synchronise raw buttons and turn each rising edge into a registered one-cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync  <= '0;
      clr_sync <= '0;
      ss_e     <= 1'b0;
      clr_e    <= 1'b0;
      ss_p     <= 1'b0;
      clr_p    <= 1'b0;
    end else begin
      ss_sync  <= {ss_sync[SYNC_STAGES-2:0], btn_ss};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], btn_clr};
      ss_e     <= ss_sync[SYNC_STAGES-1];
      clr_e    <= clr_sync[SYNC_STAGES-1];
      ss_p     <= ss_sync[SYNC_STAGES-1] & ~ss_e;
      clr_p    <= clr_sync[SYNC_STAGES-1] & ~clr_e;
    end
  end

  // One-second step of the MM:SS cascade; even digits wrap at 9, odd digits at 5
  function automatic bcd4_t bcd_step(input bcd4_t c);
    bcd4_t r;
    logic  carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (c[i] == (((i % 2) == 0) ? 4'd9 : 4'd5)) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = c[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

`ifdef STOPWATCH_LAP_EN
  logic  lap_q, lap_n;
  bcd4_t lapv, lapv_n;
`endif

  always_comb begin
    state_n = state;
    presc_n = presc;
    cnt_n   = cnt;
`ifdef STOPWATCH_LAP_EN
    lap_n   = lap_q;
    lapv_n  = lapv;
`endif
    tick    = (state == RUN) && (presc == PMAX);
    wrap_n  = tick && (cnt == 16'h5959);
    case (state)
      IDLE, PAUSE: begin
        // Clear beats start when both pulses arrive together
        if (clr_p) begin
          state_n = IDLE;
          presc_n = '0;
          cnt_n   = '0;
`ifdef STOPWATCH_LAP_EN
          lap_n   = 1'b0;
`endif
        end else if (ss_p) begin
          state_n = RUN;
        end
      end
      RUN: begin
        presc_n = tick ? '0 : PW'(presc + 1'b1);
        if (tick) cnt_n = bcd_step(cnt);
        if (ss_p) begin
          state_n = PAUSE;
`ifdef STOPWATCH_LAP_EN
        end else if (clr_p) begin
          lap_n = ~lap_q;
          if (!lap_q) lapv_n = cnt_n;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    disp_n = cnt_n;
`ifdef STOPWATCH_LAP_EN
    if (lap_n) disp_n = lapv_n;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      presc   <= '0;
      cnt     <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
      d0      <= 4'd0;
      d1      <= 4'd0;
      d2      <= 4'd0;
      d3      <= 4'd0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      cnt     <= cnt_n;
      running <= (state_n == RUN);
      wrap    <= wrap_n;
      d0      <= disp_n[0];
      d1      <= disp_n[1];
      d2      <= disp_n[2];
      d3      <= disp_n[3];
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q <= 1'b0;
      lapv  <= '0;
    end else begin
      lap_q <= lap_n;
      lapv  <= lapv_n;
    end
  end
  assign lap = lap_q;
`else
  assign lap = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV=4, SYNC_STAGES=2.
module tb_stopwatch_counter;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic       running, wrap, lap;
  logic [15:0] disp;
  int         n_vec = 0;
  int         n_err = 0;

  assign disp = {d3, d2, d1, d0};

  stopwatch_counter #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .running(running), .wrap(wrap), .lap(lap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing on a falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_disp", disp, 16'h0000);
    chk("rst_run", 16'(running), 16'h0);
    chk("rst_wrap", 16'(wrap), 16'h0);
    chk("rst_lap", 16'(lap), 16'h0);
    @(negedge clk);
    cyc(1);
    rst = 1'b1;
    cyc(2);
    chk("idle_disp", disp, 16'h0000);

    // Start: running rises on the 4th edge after the press
    btn_ss = 1'b1;
    cyc(3);
    chk("start_e3", 16'(running), 16'h0);
    cyc(1);
    chk("start_e4", 16'(running), 16'h1);
    btn_ss = 1'b0;
    cyc(39);
    chk("t39", disp, 16'h0009);
    cyc(1);
    chk("t40", disp, 16'h0010);

    // Carry into minutes tens, then wrap at 59:59
    cyc(4 * 590);
    chk("10m", disp, 16'h1000);
    cyc(4 * 2999);
    chk("5959", disp, 16'h5959);
    chk("pre_wrap", 16'(wrap), 16'h0);
    cyc(3);
    chk("5959_hold", disp, 16'h5959);
    cyc(1);
    chk("wrap_disp", disp, 16'h0000);
    chk("wrap_pulse", 16'(wrap), 16'h1);
    chk("wrap_run", 16'(running), 16'h1);
    cyc(1);
    chk("wrap_end", 16'(wrap), 16'h0);
    chk("wrap_run2", 16'(running), 16'h1);

    // Pause at 00:07 with prescaler=2, then resume finishes the partial interval
    cyc(25);
    btn_ss = 1'b1;
    cyc(4);
    chk("pause_run", 16'(running), 16'h0);
    chk("pause_disp", disp, 16'h0007);
    btn_ss = 1'b0;
    cyc(100);
    chk("pause_hold", disp, 16'h0007);
    btn_ss = 1'b1;
    cyc(4);
    chk("resume_run", 16'(running), 16'h1);
    btn_ss = 1'b0;
    cyc(1);
    chk("resume_1", disp, 16'h0007);
    cyc(1);
    chk("resume_2", disp, 16'h0008);
    cyc(3);
    chk("resume_5", disp, 16'h0008);
    cyc(1);
    chk("resume_6", disp, 16'h0009);

    // Pause on a tick edge: tick applied first
    btn_ss = 1'b1;
    cyc(4);
    chk("tick_pause", disp, 16'h0010);
    chk("tick_pause_run", 16'(running), 16'h0);
    btn_ss = 1'b0;
    cyc(3);
    btn_clr = 1'b1;
    cyc(3);
    chk("clr_pending", disp, 16'h0010);
    cyc(1);
    chk("clr_disp", disp, 16'h0000);
    chk("clr_run", 16'(running), 16'h0);
    btn_clr = 1'b0;
    cyc(3);

    // Clear while running: ignored, or lap toggle when lap is built in
    btn_ss = 1'b1;
    cyc(4);
    btn_ss = 1'b0;
    cyc(8);
    chk("run2_t8", disp, 16'h0002);
    btn_clr = 1'b1;
    cyc(4);
    chk("run_clr_disp", disp, 16'h0003);
    chk("run_clr_run", 16'(running), 16'h1);
    chk("run_clr_lap", 16'(lap), 16'(LAP));
    btn_clr = 1'b0;
    cyc(4);
    chk("lap_view", disp, LAP ? 16'h0003 : 16'h0004);
    btn_clr = 1'b1;
    cyc(4);
    chk("lap_off_disp", disp, 16'h0005);
    chk("lap_off", 16'(lap), 16'h0);
    btn_clr = 1'b0;

    // ss & clr together in PAUSE: clear wins
    btn_ss = 1'b1;
    cyc(4);
    chk("pause2", disp, 16'h0006);
    btn_ss = 1'b0;
    cyc(4);
    btn_ss = 1'b1;
    btn_clr = 1'b1;
    cyc(4);
    chk("both_pause_disp", disp, 16'h0000);
    chk("both_pause_run", 16'(running), 16'h0);
    btn_ss = 1'b0;
    btn_clr = 1'b0;
    cyc(4);

    // ss & clr together in RUN: pause, clear dropped
    btn_ss = 1'b1;
    cyc(4);
    btn_ss = 1'b0;
    cyc(5);
    chk("run3_t5", disp, 16'h0001);
    btn_ss = 1'b1;
    btn_clr = 1'b1;
    cyc(4);
    chk("both_run_disp", disp, 16'h0002);
    chk("both_run_run", 16'(running), 16'h0);
    chk("both_run_lap", 16'(lap), 16'h0);
    btn_ss = 1'b0;
    btn_clr = 1'b0;
    cyc(10);
    chk("both_run_hold", disp, 16'h0002);

    // Resume to 03:41, then async reset between edges
    btn_ss = 1'b1;
    cyc(4);
    btn_ss = 1'b0;
    cyc(875);
    chk("0341", disp, 16'h0341);
    #2 rst = 1'b0;
    #1;
    chk("arst_disp", disp, 16'h0000);
    chk("arst_run", 16'(running), 16'h0);
    chk("arst_wrap", 16'(wrap), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc(10);
    chk("post_rst_disp", disp, 16'h0000);
    chk("post_rst_run", 16'(running), 16'h0);
    btn_ss = 1'b1;
    cyc(4);
    chk("post_rst_start", 16'(running), 16'h1);
    btn_ss = 1'b0;
    cyc(4);
    chk("post_rst_t4", disp, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
